// File: rtl/zmod_pkg.sv
// Shared types and defaults for the ZMOD receive aligner.
package zmod_pkg;

   localparam int unsigned ZMOD_LANES      = 4;
   localparam int unsigned ZMOD_W          = 8;
   localparam logic [7:0]  ZMOD_TRAIN_WORD = 8'hA5;

   typedef enum logic [1:0] {
      SEARCH,
      WAIT,
      LOCKED
   } lane_state_e;

endpackage

// File: rtl/zmod_rx_align_if.sv
// Lane-data, alignment-status and payload signals between the deserializers and the aligner.
interface zmod_rx_align_if #(
   parameter int unsigned N_LANES = 4,
   parameter int unsigned W       = 8
);
   logic                 realign;
   logic                 in_valid;
   logic [N_LANES*W-1:0] in_data;
   logic [N_LANES-1:0]   bitslip;
   logic [N_LANES-1:0]   lane_locked;
   logic [N_LANES-1:0]   lane_fail;
   logic                 all_locked;
   logic                 out_valid;
   logic [N_LANES*W-1:0] out_data;

   modport master (
      output realign, in_valid, in_data,
      input  bitslip, lane_locked, lane_fail, all_locked, out_valid, out_data
   );

   modport slave (
      input  realign, in_valid, in_data,
      output bitslip, lane_locked, lane_fail, all_locked, out_valid, out_data
   );
endinterface

// File: rtl/zmod_lane_align.sv
// Single-lane word aligner: slips the deserializer until TRAIN_WORD repeats LOCK_COUNT times.
module zmod_lane_align
   import zmod_pkg::*;
#(
   parameter int unsigned  W          = ZMOD_W,
   parameter logic [W-1:0] TRAIN_WORD = W'(ZMOD_TRAIN_WORD),
   parameter int unsigned  LOCK_COUNT = 16,
   parameter int unsigned  SLIP_WAIT  = 4,
   parameter int unsigned  MAX_SLIPS  = 2 * W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         realign,
   input  logic         in_valid,
   input  logic [W-1:0] word,
   output logic         bitslip,
   output logic         locked,
   output logic         fail
);
   localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
   localparam int unsigned SW = $clog2(MAX_SLIPS + 1);
   localparam int unsigned WW = $clog2(SLIP_WAIT + 1);

   lane_state_e   state_q, state_d;
   logic [MW-1:0] match_q, match_d;
   logic [SW-1:0] slip_q, slip_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          bitslip_q, bitslip_d;
   logic          locked_q, locked_d;
   logic          fail_q, fail_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SEARCH;
         match_q   <= '0;
         slip_q    <= '0;
         wait_q    <= '0;
         bitslip_q <= 1'b0;
         locked_q  <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         match_q   <= match_d;
         slip_q    <= slip_d;
         wait_q    <= wait_d;
         bitslip_q <= bitslip_d;
         locked_q  <= locked_d;
         fail_q    <= fail_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      match_d   = match_q;
      slip_d    = slip_q;
      wait_d    = wait_q;
      bitslip_d = 1'b0;
      locked_d  = locked_q;
      fail_d    = fail_q;
      if (realign) begin
         state_d  = SEARCH;
         match_d  = '0;
         slip_d   = '0;
         wait_d   = '0;
         locked_d = 1'b0;
         fail_d   = 1'b0;
      end else begin
         unique case (state_q)
            SEARCH: begin
               if (in_valid && (word == TRAIN_WORD)) begin
                  if (match_q == MW'(LOCK_COUNT - 1)) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                     match_d  = MW'(LOCK_COUNT);
                  end else begin
                     match_d = match_q + 1'b1;
                  end
               end else if (in_valid) begin
                  bitslip_d = 1'b1;
                  match_d   = '0;
                  wait_d    = WW'(SLIP_WAIT);
                  state_d   = WAIT;
                  // The slip that reaches MAX_SLIPS flags the lane and restarts the tally.
                  if (slip_q == SW'(MAX_SLIPS - 1)) begin
                     fail_d = 1'b1;
                     slip_d = '0;
                  end else begin
                     slip_d = slip_q + 1'b1;
                  end
               end
            end
            WAIT: begin
               if (wait_q <= WW'(1)) begin
                  wait_d  = '0;
                  state_d = SEARCH;
               end else begin
                  wait_d = wait_q - 1'b1;
               end
            end
            LOCKED: begin
               state_d = LOCKED;
            end
            default: begin
               state_d = SEARCH;
            end
         endcase
      end
   end

   assign bitslip = bitslip_q;
   assign locked  = locked_q;
   assign fail    = fail_q;

endmodule

// File: rtl/zmod_rx_align.sv
// Four-lane ZMOD receive aligner: per-lane bitslip search, then forwards aligned payload words.
module zmod_rx_align
   import zmod_pkg::*;
#(
   parameter int unsigned  N_LANES    = ZMOD_LANES,
   parameter int unsigned  W          = ZMOD_W,
   parameter logic [W-1:0] TRAIN_WORD = W'(ZMOD_TRAIN_WORD),
   parameter int unsigned  LOCK_COUNT = 16,
   parameter int unsigned  SLIP_WAIT  = 4,
   parameter int unsigned  MAX_SLIPS  = 2 * W
) (
   input logic             clk,
   input logic             rst_n,
   zmod_rx_align_if.slave  bus
);
   logic [N_LANES-1:0]   bitslip;
   logic [N_LANES-1:0]   lane_locked;
   logic [N_LANES-1:0]   lane_fail;
   logic                 all_locked_q;
   logic                 out_valid_q;
   logic [N_LANES*W-1:0] out_data_q;

   for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      zmod_lane_align #(
         .W          (W),
         .TRAIN_WORD (TRAIN_WORD),
         .LOCK_COUNT (LOCK_COUNT),
         .SLIP_WAIT  (SLIP_WAIT),
         .MAX_SLIPS  (MAX_SLIPS)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .realign  (bus.realign),
         .in_valid (bus.in_valid),
         .word     (bus.in_data[i*W +: W]),
         .bitslip  (bitslip[i]),
         .locked   (lane_locked[i]),
         .fail     (lane_fail[i])
      );
   end

   // out_data is deliberately left holding across realign; only the valid flag drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         all_locked_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
      end else if (bus.realign) begin
         all_locked_q <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         all_locked_q <= &lane_locked;
         out_valid_q  <= bus.in_valid & all_locked_q;
         if (bus.in_valid && all_locked_q) begin
            out_data_q <= bus.in_data;
         end
      end
   end

   assign bus.bitslip     = bitslip;
   assign bus.lane_locked = lane_locked;
   assign bus.lane_fail   = lane_fail;
   assign bus.all_locked  = all_locked_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;

endmodule

// File: tb/tb_zmod_rx_align.sv
// Bench for zmod_rx_align: lanes modelled as rotators that advance on bitslip, checked per cycle.
module tb_zmod_rx_align;
   localparam int         NL = 4;
   localparam int         W  = 8;
   localparam logic [7:0] T  = 8'hA5;
   localparam int         LC = 16;
   localparam int         SW = 4;
   localparam int         MS = 16;

   typedef struct packed {
      logic [3:0][2:0] rot;
      logic [3:0]      stuck;
      logic            corrupt;
      logic            realign_mid;
      logic            rnd_valid;
      logic [3:0][3:0] exp_slips;
      logic [3:0]      exp_locked;
      logic [3:0]      exp_fail;
      logic            exp_all;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   zmod_rx_align_if #(.N_LANES(NL), .W(W)) bus ();

   zmod_rx_align #(
      .N_LANES    (NL),
      .W          (W),
      .TRAIN_WORD (T),
      .LOCK_COUNT (LC),
      .SLIP_WAIT  (SW),
      .MAX_SLIPS  (MS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rot[NL];
   int tot_slips[NL];
   int last_slip[NL];
   int m[NL];
   int ign[NL];
   int slc[NL];
   logic [NL-1:0]   p_bs, p_lk, p_fl;
   logic            p_all, p_ov;
   logic [NL*W-1:0] p_od;
   vec_t cur;
   vec_t vecs[6];
   int  payload_sent;
   bit  corrupted, realigned, realign_prev;

   function automatic logic [7:0] rotl(input logic [7:0] x, input int r);
      logic [7:0] y;
      y = x;
      for (int i = 0; i < r; i++) y = {y[6:0], y[7]};
      return y;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int l = 0; l < NL; l++) begin
         m[l] = 0;
         ign[l] = 0;
         slc[l] = 0;
      end
      p_bs = '0;
      p_lk = '0;
      p_fl = '0;
      p_all = 1'b0;
      p_ov = 1'b0;
   endtask

   task automatic do_reset();
      bus.realign = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = '0;
      rst_n = 1'b0;
      model_clear();
      p_od = '0;
      repeat (3) begin
         @(negedge clk);
         cyc++;
         check("reset_flags", {bus.bitslip, bus.lane_locked, bus.lane_fail, bus.all_locked,
                               bus.out_valid}, 32'd0);
         check("reset_out_data", bus.out_data, 32'd0);
      end
      rst_n = 1'b1;
      #1;
      check("release_bitslip", {28'd0, bus.bitslip}, 32'd0);
   endtask

   // Compare against the prediction, react to bitslip like a deserializer, drive the next word
   // and predict what the spec's rules give after the coming edge.
   task automatic step();
      logic            v, re, pay, new_all, new_ov, bs;
      logic [7:0]      base, wd;
      logic [NL*W-1:0] d;
      check("bitslip", {28'd0, bus.bitslip}, {28'd0, p_bs});
      check("lane_locked", {28'd0, bus.lane_locked}, {28'd0, p_lk});
      check("lane_fail", {28'd0, bus.lane_fail}, {28'd0, p_fl});
      check("all_locked", {31'd0, bus.all_locked}, {31'd0, p_all});
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, p_ov});
      if (p_ov) check("out_data", bus.out_data, p_od);
      if (realign_prev)
         check("realign_clear", {bus.all_locked, bus.out_valid, bus.lane_locked}, 32'd0);
      for (int l = 0; l < NL; l++) begin
         if (bus.bitslip[l]) begin
            if (last_slip[l] >= 0)
               check("slip_gap_ok", {31'd0, (cyc - last_slip[l]) >= SW + 1}, 32'd1);
            last_slip[l] = cyc;
            tot_slips[l]++;
            rot[l] = (rot[l] + W - 1) % W;
         end
      end
      v = cur.rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      pay = p_all;
      re = 1'b0;
      if (cur.realign_mid && !realigned && pay && payload_sent == 8) begin
         re = 1'b1;
         realigned = 1'b1;
      end
      base = cur.rnd_valid ? 8'($urandom) : 8'(payload_sent);
      for (int l = 0; l < NL; l++) begin
         wd = cur.stuck[l] ? 8'h00 : rotl(pay ? (base ^ 8'(l * 37)) : T, rot[l]);
         if (cur.corrupt && !corrupted && l == 0 && !pay && v && !p_lk[0] && ign[0] == 0 &&
             m[0] == 10) begin
            wd = 8'hFF;
            corrupted = 1'b1;
         end
         d[l*W +: W] = wd;
      end
      bus.in_valid = v;
      bus.in_data = d;
      bus.realign = re;
      if (pay && v) payload_sent++;
      if (re) begin
         model_clear();
         payload_sent = 0;
      end else begin
         new_all = &p_lk;
         new_ov = v & p_all;
         if (new_ov) p_od = d;
         for (int l = 0; l < NL; l++) begin
            bs = 1'b0;
            if (!p_lk[l]) begin
               if (ign[l] > 0) begin
                  ign[l]--;
               end else if (v) begin
                  if (d[l*W +: W] == T) begin
                     m[l]++;
                     if (m[l] == LC) p_lk[l] = 1'b1;
                  end else begin
                     m[l] = 0;
                     bs = 1'b1;
                     ign[l] = SW;
                     slc[l]++;
                     if (slc[l] == MS) begin
                        p_fl[l] = 1'b1;
                        slc[l] = 0;
                     end
                  end
               end
            end
            p_bs[l] = bs;
         end
         p_all = new_all;
         p_ov = new_ov;
      end
      realign_prev = re;
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_vec(input vec_t v);
      int extra;
      bit done;
      cur = v;
      do_reset();
      for (int l = 0; l < NL; l++) begin
         rot[l] = int'(v.rot[l]);
         tot_slips[l] = 0;
         last_slip[l] = -1;
      end
      payload_sent = 0;
      corrupted = 1'b0;
      realigned = 1'b0;
      realign_prev = 1'b0;
      extra = -1;
      done = 1'b0;
      for (int k = 0; k < 800; k++) begin
         step();
         if (v.exp_all) begin
            if (extra < 0 && payload_sent >= 16 && (!v.realign_mid || realigned)) extra = 3;
            else if (extra > 0) extra--;
            if (extra == 0) begin
               done = 1'b1;
               break;
            end
         end else if (k >= 300) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) check("lock_budget", 32'd0, 32'd1);
      for (int l = 0; l < NL; l++)
         if (!v.stuck[l]) check("slip_count", tot_slips[l], {28'd0, v.exp_slips[l]});
      check("end_lane_locked", {28'd0, bus.lane_locked}, {28'd0, v.exp_locked});
      check("end_lane_fail", {28'd0, bus.lane_fail}, {28'd0, v.exp_fail});
      check("end_all_locked", {31'd0, bus.all_locked}, {31'd0, v.exp_all});
   endtask

   initial begin
      bus.realign = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = '0;
      p_od = '0;
      model_clear();
      // rot / stuck / corrupt / realign_mid / rnd_valid / slips / locked / fail / all
      vecs[0] = '{{3'd7, 3'd3, 3'd1, 3'd0}, 4'b0000, 1'b0, 1'b0, 1'b0,
                  {4'd7, 4'd3, 4'd1, 4'd0}, 4'b1111, 4'b0000, 1'b1};
      vecs[1] = '{{3'd7, 3'd3, 3'd1, 3'd0}, 4'b0100, 1'b0, 1'b0, 1'b0,
                  {4'd7, 4'd0, 4'd1, 4'd0}, 4'b1011, 4'b0100, 1'b0};
      // The corrupt word slips lane 0 off alignment, so the rotator needs 7 further slips.
      vecs[2] = '{{3'd0, 3'd0, 3'd2, 3'd0}, 4'b0000, 1'b1, 1'b0, 1'b0,
                  {4'd0, 4'd0, 4'd2, 4'd8}, 4'b1111, 4'b0000, 1'b1};
      vecs[3] = '{{3'd7, 3'd3, 3'd1, 3'd0}, 4'b0000, 1'b0, 1'b1, 1'b0,
                  {4'd7, 4'd3, 4'd1, 4'd0}, 4'b1111, 4'b0000, 1'b1};
      for (int i = 4; i < 6; i++) begin
         vecs[i] = '0;
         vecs[i].rnd_valid = 1'b1;
         vecs[i].exp_locked = 4'b1111;
         vecs[i].exp_all = 1'b1;
         for (int l = 0; l < NL; l++) begin
            vecs[i].rot[l] = 3'($urandom_range(0, 7));
            vecs[i].exp_slips[l] = {1'b0, vecs[i].rot[l]};
         end
      end
      @(negedge clk);
      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Reset asserted in the cycle bitslip is high: it must fall without a clock edge.
      cur = vecs[0];
      do_reset();
      for (int l = 0; l < NL; l++) begin
         rot[l] = int'(vecs[0].rot[l]);
         tot_slips[l] = 0;
         last_slip[l] = -1;
      end
      payload_sent = 0;
      realign_prev = 1'b0;
      for (int k = 0; k < 60 && bus.bitslip == '0; k++) step();
      check("saw_bitslip", {31'd0, bus.bitslip != '0}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_bitslip_drop", {28'd0, bus.bitslip}, 32'd0);
      run_vec(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
